// File: rtl/seq_mult_16b_pkg.sv
// rtl/seq_mult_16b_pkg.sv - shared constants and state encoding for the sequential multiplier
package seq_mult_16b_pkg;

   localparam int WORD_W    = 16;
   localparam int MUL_ITERS = 16;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage

// File: rtl/full_adder_16bit.sv
// rtl/full_adder_16bit.sv - 16-bit ripple-carry adder with carry in and carry out
module full_adder_16bit (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout
);

   logic [16:0] carry;

   assign carry[0] = cin;

   // one full-adder cell per bit, carry rippling upward
   for (genvar i = 0; i < 16; i++) begin : g_bit
      assign sum[i]       = a[i] ^ b[i] ^ carry[i];
      assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
   end

   assign cout = carry[16];

endmodule

// File: rtl/seq_mult_16b.sv
// rtl/seq_mult_16b.sv - 16-iteration shift-add multiplier with start/busy/done; MUL_SIGNED_EN selects two's complement
module seq_mult_16b
   import seq_mult_16b_pkg::*;
#(
   parameter int W     = 16,
   parameter int CNT_W = 5
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] product
);

   state_t              state;
   logic [WORD_W-1:0]   mcand;
   logic [WORD_W-1:0]   acc;
   logic [WORD_W-1:0]   mplr;
   logic [CNT_W-1:0]    count;

   logic                last_iter;
   logic [WORD_W-1:0]   add_b;
   logic                add_cin;
   logic [WORD_W-1:0]   add_sum;
   logic                add_cout;
   logic                shift_msb;

   assign last_iter = (count == CNT_W'(MUL_ITERS - 1));

`ifdef MUL_SIGNED_EN
   // the final multiplier bit carries negative weight, so that step subtracts the multiplicand
   always_comb begin
      add_b   = '0;
      add_cin = 1'b0;
      if (mplr[0]) begin
         if (last_iter) begin
            add_b   = ~mcand;
            add_cin = 1'b1;
         end else begin
            add_b   = mcand;
         end
      end
   end

   // bit 16 of the sign-extended sum keeps the arithmetic shift exact even on 16-bit overflow
   assign shift_msb = acc[WORD_W-1] ^ add_b[WORD_W-1] ^ add_cout;
`else
   // unsigned: add the multiplicand only where the current multiplier bit is set
   always_comb begin
      add_b   = mplr[0] ? mcand : '0;
      add_cin = 1'b0;
   end

   // carry-out becomes the new top bit so nothing is lost in the shift
   assign shift_msb = add_cout;
`endif

   full_adder_16bit u_adder (
      .a    (acc),
      .b    (add_b),
      .cin  (add_cin),
      .sum  (add_sum),
      .cout (add_cout)
   );

   assign busy    = (state == RUN);
   assign product = {acc, mplr};

   // control FSM plus the acc/mplr shift register; done is registered as a one-cycle pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         done  <= 1'b0;
         mcand <= '0;
         acc   <= '0;
         mplr  <= '0;
         count <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  mcand <= a;
                  acc   <= '0;
                  mplr  <= b;
                  count <= '0;
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               acc   <= {shift_msb, add_sum[WORD_W-1:1]};
               mplr  <= {add_sum[0], mplr[WORD_W-1:1]};
               count <= count + 1'b1;
               if (last_iter) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_mult_16b.sv
// tb/tb_seq_mult_16b.sv - randomized and directed self-checking bench for seq_mult_16b
module tb_seq_mult_16b;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] op_a = '0;
   logic [15:0] op_b = '0;
   logic        busy;
   logic        done;
   logic [31:0] product;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   seq_mult_16b #(.W(16), .CNT_W(5)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .a       (op_a),
      .b       (op_b),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   always #5 clk = ~clk;

   // reference: a multiply takes 16 busy cycles then a done cycle carrying the full product
   int          m_left = 0;
   bit          m_done = 1'b0;
   logic [31:0] m_prod = '0;
   logic [31:0] m_res  = '0;

   function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
`ifdef MUL_SIGNED_EN
      logic signed [31:0] s;
      s = $signed(x) * $signed(y);
      return s;
`else
      return {16'h0, x} * {16'h0, y};
`endif
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_left = 0;
         m_done = 1'b0;
         m_prod = '0;
      end else if (m_left > 0) begin
         m_left = m_left - 1;
         if (m_left == 0) begin
            m_done = 1'b1;
            m_prod = m_res;
         end
      end else begin
         m_done = 1'b0;
         if (start) begin
            m_left = 16;
            m_res  = ref_mul(op_a, op_b);
         end
      end
   end

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   // per-cycle comparison against the reference
   always @(negedge clk) begin
      if (cmp_en) begin
         check32("busy", {31'h0, busy}, {31'h0, (m_left > 0)});
         check32("done", {31'h0, done}, {31'h0, m_done});
         if (m_left == 0) check32("product", product, m_prod);
      end
   end

   task automatic start_op(input logic [15:0] x, input logic [15:0] y);
      @(negedge clk);
      start = 1'b1;
      op_a  = x;
      op_b  = y;
      @(negedge clk);
      start = 1'b0;
      op_a  = $urandom;
      op_b  = $urandom;
   endtask

   // counts negedges from cycle 1 (already consumed by start_op) until done
   task automatic wait_done(output int lat);
      lat = 1;
      while (done !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL done_timeout actual=none expected=done within 40 cycles");
      end
   endtask

   task automatic run_op(input string name, input logic [15:0] x, input logic [15:0] y,
                         input logic [31:0] exp);
      int lat;
      start_op(x, y);
      wait_done(lat);
      check32({name, "_latency"}, lat, 17);
      check32({name, "_product"}, product, exp);
   endtask

   initial begin
      int lat;
      repeat (2) @(negedge clk);
      check32("reset_busy", {31'h0, busy}, 32'h0);
      check32("reset_done", {31'h0, done}, 32'h0);
      check32("reset_product", product, 32'h0);
      #2 rst_n = 1'b1;
      cmp_en = 1'b1;

      run_op("mul_3x5", 16'd3, 16'd5, 32'h0000000F);
      repeat (3) @(negedge clk);
      check32("hold_3x5", product, 32'h0000000F);
`ifdef MUL_SIGNED_EN
      run_op("mul_ffff", 16'hFFFF, 16'hFFFF, 32'h00000001);
      run_op("mul_neg1x2", 16'hFFFF, 16'h0002, 32'hFFFFFFFE);
`else
      run_op("mul_ffff", 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
`endif
      run_op("mul_b0", 16'h1234, 16'h0000, 32'h0);
      run_op("mul_a0", 16'h0000, 16'hABCD, 32'h0);

      // start while busy is ignored
      start_op(16'd11, 16'd13);
      repeat (3) @(negedge clk);
      start = 1'b1; op_a = 16'd7; op_b = 16'd7;
      @(negedge clk);
      start = 1'b0;
      lat = 5;
      while (done !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check32("ignore_latency", lat, 17);
      check32("ignore_product", product, 32'd143);

      // asynchronous reset mid-operation
      start_op(16'h0F0F, 16'h1111);
      repeat (6) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check32("abort_busy", {31'h0, busy}, 32'h0);
      check32("abort_done", {31'h0, done}, 32'h0);
      check32("abort_product", product, 32'h0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      lat = 0;
      repeat (20) begin
         @(negedge clk);
         if (done === 1'b1) lat++;
      end
      check32("abort_no_done", lat, 0);
      run_op("after_abort", 16'd100, 16'd200, 32'd20000);

      // back-to-back: start held through the done cycle
      start_op(16'd6, 16'd7);
      wait_done(lat);
      check32("b2b_first", product, 32'd42);
      start = 1'b1; op_a = 16'd2; op_b = 16'd9;
      @(negedge clk);
      start = 1'b0;
      check32("b2b_busy", {31'h0, busy}, 32'h1);
      wait_done(lat);
      check32("b2b_latency", lat, 17);
      check32("b2b_product", product, 32'h00000012);

      // randomized traffic, checked every cycle by the compare process
      repeat (1500) begin
         @(negedge clk);
         start = ($urandom_range(0, 3) == 0);
         op_a  = $urandom;
         op_b  = $urandom;
         if ($urandom_range(0, 7) == 0) begin
            op_a = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'h8000;
            op_b = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'h8000;
         end
      end
      @(negedge clk);
      start = 1'b0;
      repeat (20) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
